// File: rtl/systolic_loader.sv
// systolic_loader: collects eight streamed elements (a11, a12, a21, a22,
// b11, b12, b21, b22) into one A/B 2x2 operand set and launches it with a
// one-cycle out_val pulse. Launches are spaced by at least LAUNCH_GAP
// cycles because the multiply stage downstream cannot stall.
// Optional feature macro: LOADER_ERR_CHK_EN enables s_last framing checks
// and the err pulse; without it s_last is ignored and err is tied low.
module systolic_loader #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LAUNCH_GAP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_val,
  output logic             s_rdy,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             out_val,
  output logic [WIDTH-1:0] a11,
  output logic [WIDTH-1:0] a12,
  output logic [WIDTH-1:0] a21,
  output logic [WIDTH-1:0] a22,
  output logic [WIDTH-1:0] b11,
  output logic [WIDTH-1:0] b12,
  output logic [WIDTH-1:0] b21,
  output logic [WIDTH-1:0] b22,
  output logic             err
);

  typedef enum logic {FILL, FULL} state_e;

  localparam logic [7:0] GAP_RELOAD = 8'(LAUNCH_GAP - 1);

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       gap_q, gap_d;
  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] op_q   [8];
  logic             out_val_q;
  logic             accept;
  logic             launch;
  logic             frame_err;

  // Next-state, index and gap-counter logic; s_rdy is high only while filling.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    launch    = 1'b0;
    frame_err = 1'b0;
    s_rdy     = (state_q == FILL);
    accept    = s_val & s_rdy;
    case (state_q)
      FILL: begin
        if (accept) begin
`ifdef LOADER_ERR_CHK_EN
          if (s_last != (idx_q == 3'd7)) begin
            frame_err = 1'b1;
            idx_d     = '0;
          end else
`endif
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      FULL: begin
        if (gap_q == '0) begin
          launch  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (launch) begin
      gap_d = GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - 8'd1;
    end else begin
      gap_d = gap_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Assembly register: one slot written per accepted element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) slot_q[i] <= '0;
    end else if (accept) begin
      slot_q[idx_q] <= s_data;
    end
  end

  // Operand output registers and launch pulse; operands hold between launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) op_q[i] <= '0;
      out_val_q <= 1'b0;
    end else begin
      out_val_q <= launch;
      if (launch) begin
        for (int unsigned i = 0; i < 8; i++) op_q[i] <= slot_q[i];
      end
    end
  end

`ifdef LOADER_ERR_CHK_EN
  logic err_q;

  // Framing error pulse, one cycle after the offending accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= frame_err;
  end

  assign err = err_q;
`else
  logic unused_err_chk;
  assign unused_err_chk = s_last ^ frame_err;
  assign err            = 1'b0;
`endif

  assign out_val = out_val_q;
  assign a11 = op_q[0];
  assign a12 = op_q[1];
  assign a21 = op_q[2];
  assign a22 = op_q[3];
  assign b11 = op_q[4];
  assign b12 = op_q[5];
  assign b21 = op_q[6];
  assign b22 = op_q[7];

endmodule
